rdyack_fifo: RTL and testbench
==============================

Name: rdyack_fifo

Overview:
- Parametrised synchronous FIFO with rdy/ack handshake on both sides and integrated data storage.
- Any depth NDATA ≥ 2; power of two not required.
- Provides occupancy count, almost-full/almost-empty flags and a synchronous flush.
- Sits between pipeline stages as the general buffering element, wherever a bare 2-slot forwarder is insufficient.

Parameters:
- BW, 8, data width in bits.
- NDATA, 4, number of storage entries; must be ≥ 2.
- AFULL_TH, 3, o_afull asserted when count ≥ AFULL_TH; legal range 1..NDATA.
- AEMPTY_TH, 1, o_aempty asserted when count ≤ AEMPTY_TH; legal range 0..NDATA-1.
- CW, $clog2(NDATA+1), count width (derived; not overridden).

Ports:
- i_clk  in  1  clock.
- i_rstn  in  1  reset, asynchronous, active-low.
- i_flush  in  1  synchronous clear of all contents.
- src_rdy  in  1  source has valid data.
- src_ack  out  1  source word accepted this cycle.
- i_src_data  in  BW  source data.
- dst_rdy  out  1  FIFO holds valid head data.
- dst_ack  in  1  sink consumes head this cycle.
- o_dst_data  out  BW  head data.
- o_count  out  CW  current occupancy, 0..NDATA.
- o_afull  out  1  almost-full flag.
- o_aempty  out  1  almost-empty flag.

Behaviour:
- Handshake rules:
  - A transfer occurs on a cycle where rdy && ack.
  - Source holds src_rdy and i_src_data stable until src_ack.
  - dst_ack is legal only while dst_rdy = 1; dst_ack with dst_rdy = 0 is ignored.
- Reset (async, i_rstn = 0):
  - wptr = 0, rptr = 0, count = 0.
  - dst_rdy = 0, src_ack = 0, o_count = 0, o_afull = (AFULL_TH == 0 ? 1 : 0) → effectively 0, o_aempty = 1.
  - Storage contents are not reset; o_dst_data is don't-care while dst_rdy = 0.
- Accept/valid logic:
  - full = (count == NDATA).
  - src_ack = src_rdy && !full && !i_flush. src_ack does not depend combinationally on dst_ack; there is no write-through while full.
  - dst_rdy = (count != 0), a registered-state function. o_dst_data = mem[rptr] (first-word fall-through).
- Latency: a word written in cycle t is visible at dst in cycle t+1. Minimum latency is 1; there is no combinational src→dst bypass.
- Pointer update:
  - wr = src_ack; rd = dst_ack && dst_rdy.
  - On wr: mem[wptr] ← i_src_data, wptr ← (wptr == NDATA-1) ? 0 : wptr+1.
  - On rd: rptr wraps the same way.
- Count update:
  - wr && !rd: count+1.
  - rd && !wr: count−1.
  - Both or neither: unchanged.
  - Simultaneous read and write at count = 1 is legal; the FIFO stays non-empty with the new word at head next cycle.
- Flags: o_count, o_afull and o_aempty are derived from the registered count, so they are valid in the same cycle as dst_rdy.
- Flush (i_flush = 1):
  - src_ack is forced 0.
  - Next edge: wptr = rptr = 0, count = 0.
  - Any dst_ack in the flush cycle is discarded; no pop is counted.
  - dst_rdy still reflects current state during the flush cycle; sinks must ignore it.
- Boundary conditions:
  - Full: src_ack = 0 even if dst_ack = 1. The write is accepted one cycle after the pop.
  - Empty: dst_ack is ignored and count does not underflow.
  - Pointer wrap: at NDATA-1 → 0, correct for non-power-of-two NDATA (e.g. 3, 5).
  - Reset mid-operation: all state is cleared immediately; handshakes resume after i_rstn deasserts.
- Assertions (sim only):
  - count ≤ NDATA at all times.
  - No src_ack while full.
  - No rd while count == 0.
  - NDATA ≥ 2 checked at elaboration.

Test Plan:
- Fill/drain, NDATA=4, BW=8:
  - Push 0x11, 0x22, 0x33, 0x44 with dst_ack = 0 → count = 4, src_ack = 0 on 5th push attempt, o_afull = 1.
  - Drain → outputs 0x11..0x44 in order, o_aempty = 1 at count ≤ 1.
- Latency: push 0xA5 at cycle 0 into empty FIFO → dst_rdy = 1 and o_dst_data = 0xA5 at cycle 1, o_count = 1.
- Streaming: src_rdy and dst_ack held 1 for 20 cycles, counter data → count stays at 1 after first cycle, one word per cycle, data in order.
- Non-power-of-two, NDATA=3:
  - 10 random push/pop rounds → pointer wraps 2→0, scoreboard matches, count never exceeds 3.
- Flush at count = 3 with simultaneous src_rdy and dst_ack:
  - src_ack = 0.
  - Next cycle count = 0, dst_rdy = 0.
  - Subsequent push of 0x5A reads back as 0x5A.
- Async reset asserted mid-stream at count = 2 → dst_rdy = 0, o_count = 0 and o_aempty = 1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/rdyack_fifo.sv
`default_nettype none
// ============================================================================
// Module   : rdyack_fifo
// Purpose  : Parametrised synchronous FIFO with rdy/ack handshakes on both
//            sides, first-word fall-through read data, occupancy count,
//            almost-full / almost-empty flags and a synchronous flush.
//            Depth NDATA may be any value >= 2 (power of two not required).
// Ports    : i_clk       clock
//            i_rstn      asynchronous active-low reset
//            i_flush     synchronous clear of all contents
//            src_rdy     source offers a word
//            src_ack     source word accepted this cycle
//            i_src_data  source data
//            dst_rdy     head word valid
//            dst_ack     sink consumes head this cycle
//            o_dst_data  head data (don't-care while dst_rdy = 0)
//            o_count     occupancy 0..NDATA
//            o_afull     count >= AFULL_TH
//            o_aempty    count <= AEMPTY_TH
// Revision : 1.0 - initial release
// ============================================================================
module rdyack_fifo #(
    parameter int BW        = 8,
    parameter int NDATA     = 4,
    parameter int AFULL_TH  = 3,
    parameter int AEMPTY_TH = 1,
    parameter int CW        = $clog2(NDATA + 1)
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_flush,
    input  logic          src_rdy,
    output logic          src_ack,
    input  logic [BW-1:0] i_src_data,
    output logic          dst_rdy,
    input  logic          dst_ack,
    output logic [BW-1:0] o_dst_data,
    output logic [CW-1:0] o_count,
    output logic          o_afull,
    output logic          o_aempty
);

    localparam int              c_PW   = $clog2(NDATA);
    localparam logic [c_PW-1:0] c_LAST = c_PW'(NDATA - 1);
    localparam logic [CW-1:0]   c_FULL = CW'(NDATA);

    logic [BW-1:0]   r_mem [NDATA];
    logic [c_PW-1:0] r_wptr;
    logic [c_PW-1:0] r_rptr;
    logic [CW-1:0]   r_count;

    logic w_full;
    logic w_empty;
    logic w_wr;
    logic w_rd;

    // Accept/valid are functions of registered state only: src_ack never
    // looks at dst_ack, so a full FIFO cannot accept in the cycle it pops.
    assign w_full  = (r_count == c_FULL);
    assign w_empty = (r_count == '0);
    assign w_wr    = src_rdy && !w_full && !i_flush;
    // A pop during flush is discarded; the flush clears everything anyway.
    assign w_rd    = dst_ack && !w_empty && !i_flush;

    assign src_ack    = w_wr;
    assign dst_rdy    = !w_empty;
    assign o_dst_data = r_mem[r_rptr];
    assign o_count    = r_count;
    assign o_afull    = (r_count >= CW'(AFULL_TH));
    assign o_aempty   = (r_count <= CW'(AEMPTY_TH));

    // Storage is intentionally not reset.
    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= i_src_data;
        end
    end

    // Explicit wrap compare keeps the pointers correct for non-power-of-two
    // depths.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (i_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= (r_wptr == c_LAST) ? '0 : r_wptr + c_PW'(1);
            end
            if (w_rd) begin
                r_rptr <= (r_rptr == c_LAST) ? '0 : r_rptr + c_PW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_count <= '0;
        end else if (i_flush) begin
            r_count <= '0;
        end else begin
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifndef SYNTHESIS
    generate
        if (NDATA < 2) begin : g_ndata_check
            $error("rdyack_fifo: NDATA must be >= 2");
        end
    endgenerate

    a_count_max : assert property (@(posedge i_clk) disable iff (!i_rstn)
        r_count <= c_FULL);
    a_no_ack_full : assert property (@(posedge i_clk) disable iff (!i_rstn)
        w_full |-> !src_ack);
    a_no_rd_empty : assert property (@(posedge i_clk) disable iff (!i_rstn)
        w_rd |-> !w_empty);
`endif

endmodule
`default_nettype wire

// File: tb/tb_rdyack_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_rdyack_fifo
// Purpose  : Self-checking bench for rdyack_fifo. One instance at NDATA=4
//            for the directed vector table, streaming and reset checks; one
//            at NDATA=3 for randomized traffic against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rdyack_fifo;

    logic clk;
    logic rstn;

    // NDATA = 4 instance
    logic       s4_flush, s4_src_rdy, s4_src_ack, s4_dst_rdy, s4_dst_ack;
    logic [7:0] s4_src_data, s4_dst_data;
    logic [2:0] s4_count;
    logic       s4_afull, s4_aempty;

    // NDATA = 3 instance
    logic       s3_flush, s3_src_rdy, s3_src_ack, s3_dst_rdy, s3_dst_ack;
    logic [7:0] s3_src_data, s3_dst_data;
    logic [1:0] s3_count;
    logic       s3_afull, s3_aempty;

    int n_tests;
    int n_fail;

    rdyack_fifo #(.BW(8), .NDATA(4), .AFULL_TH(3), .AEMPTY_TH(1)) u_dut4 (
        .i_clk(clk), .i_rstn(rstn), .i_flush(s4_flush),
        .src_rdy(s4_src_rdy), .src_ack(s4_src_ack), .i_src_data(s4_src_data),
        .dst_rdy(s4_dst_rdy), .dst_ack(s4_dst_ack), .o_dst_data(s4_dst_data),
        .o_count(s4_count), .o_afull(s4_afull), .o_aempty(s4_aempty)
    );

    rdyack_fifo #(.BW(8), .NDATA(3), .AFULL_TH(2), .AEMPTY_TH(1)) u_dut3 (
        .i_clk(clk), .i_rstn(rstn), .i_flush(s3_flush),
        .src_rdy(s3_src_rdy), .src_ack(s3_src_ack), .i_src_data(s3_src_data),
        .dst_rdy(s3_dst_rdy), .dst_ack(s3_dst_ack), .o_dst_data(s3_dst_data),
        .o_count(s3_count), .o_afull(s3_afull), .o_aempty(s3_aempty)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       src_rdy;
        logic [7:0] data;
        logic       dst_ack;
        logic       flush;
        logic       e_sack;
        logic       e_drdy;
        logic [2:0] e_cnt;
        logic [7:0] e_data;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic sr, input logic [7:0] d, input logic ack,
                       input logic fl, input logic es, input logic ed,
                       input logic [2:0] ec, input logic [7:0] edat);
        vec_t v;
        v = '{src_rdy: sr, data: d, dst_ack: ack, flush: fl,
              e_sack: es, e_drdy: ed, e_cnt: ec, e_data: edat};
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    // Check all NDATA=4 outputs against expected state (thresholds 3 / 1).
    task automatic chk4(input string tag, input int idx, input logic es,
                        input logic ed, input int ec, input logic [7:0] edat);
        chk({tag, "_src_ack"}, idx, int'(s4_src_ack), int'(es));
        chk({tag, "_dst_rdy"}, idx, int'(s4_dst_rdy), int'(ed));
        chk({tag, "_count"},   idx, int'(s4_count), ec);
        chk({tag, "_afull"},   idx, int'(s4_afull), int'(ec >= 3));
        chk({tag, "_aempty"},  idx, int'(s4_aempty), int'(ec <= 1));
        if (ed) chk({tag, "_data"}, idx, int'(s4_dst_data), int'(edat));
    endtask

    task automatic idle4();
        s4_src_rdy = 0; s4_src_data = 0; s4_dst_ack = 0; s4_flush = 0;
    endtask

    initial begin
        logic [7:0] q[$];
        logic       acc;
        logic       e_sack;

        clk = 0; rstn = 0; n_tests = 0; n_fail = 0;
        idle4();
        s3_src_rdy = 0; s3_src_data = 0; s3_dst_ack = 0; s3_flush = 0;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #2;
        chk4("reset", 0, 1'b0, 1'b0, 0, 8'h00);
        chk("reset3_dst_rdy", 0, int'(s3_dst_rdy), 0);
        chk("reset3_aempty",  0, int'(s3_aempty), 1);
        @(posedge clk); #1 rstn = 1;

        // ---------------- directed vector table (NDATA=4) ----------------
        // sr  data  ack fl | sack drdy cnt head
        add(1, 8'h11, 0, 0,  1, 0, 0, 8'h00);   // fill
        add(1, 8'h22, 0, 0,  1, 1, 1, 8'h11);
        add(1, 8'h33, 0, 0,  1, 1, 2, 8'h11);
        add(1, 8'h44, 0, 0,  1, 1, 3, 8'h11);
        add(1, 8'h55, 0, 0,  0, 1, 4, 8'h11);   // 5th push refused
        add(0, 8'h00, 1, 0,  0, 1, 4, 8'h11);   // drain
        add(0, 8'h00, 1, 0,  0, 1, 3, 8'h22);
        add(0, 8'h00, 1, 0,  0, 1, 2, 8'h33);
        add(0, 8'h00, 1, 0,  0, 1, 1, 8'h44);
        add(0, 8'h00, 0, 0,  0, 0, 0, 8'h00);
        add(1, 8'hA5, 0, 0,  1, 0, 0, 8'h00);   // latency: push into empty
        add(0, 8'h00, 0, 0,  0, 1, 1, 8'hA5);   // visible next cycle
        add(0, 8'h00, 1, 0,  0, 1, 1, 8'hA5);
        add(0, 8'h00, 0, 0,  0, 0, 0, 8'h00);
        add(1, 8'h01, 0, 0,  1, 0, 0, 8'h00);   // refill
        add(1, 8'h02, 0, 0,  1, 1, 1, 8'h01);
        add(1, 8'h03, 0, 0,  1, 1, 2, 8'h01);
        add(1, 8'h04, 0, 0,  1, 1, 3, 8'h01);
        add(1, 8'h05, 1, 0,  0, 1, 4, 8'h01);   // full: pop, no write-through
        add(1, 8'h05, 0, 0,  1, 1, 3, 8'h02);   // accepted one cycle later
        add(0, 8'h00, 1, 0,  0, 1, 4, 8'h02);   // pop -> count 3
        add(1, 8'h77, 1, 1,  0, 1, 3, 8'h03);   // flush with push+pop
        add(0, 8'h00, 0, 0,  0, 0, 0, 8'h00);
        add(1, 8'h5A, 0, 0,  1, 0, 0, 8'h00);
        add(0, 8'h00, 0, 0,  0, 1, 1, 8'h5A);
        add(0, 8'h00, 1, 0,  0, 1, 1, 8'h5A);
        add(0, 8'h00, 1, 0,  0, 0, 0, 8'h00);   // ack while empty ignored
        add(0, 8'h00, 0, 0,  0, 0, 0, 8'h00);   // no underflow

        for (int i = 0; i < vq.size(); i++) begin
            @(posedge clk); #1;
            s4_src_rdy  = vq[i].src_rdy;
            s4_src_data = vq[i].data;
            s4_dst_ack  = vq[i].dst_ack;
            s4_flush    = vq[i].flush;
            #1;
            chk4("vec", i, vq[i].e_sack, vq[i].e_drdy, int'(vq[i].e_cnt), vq[i].e_data);
        end

        // ---------------- streaming (NDATA=4) ----------------
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            s4_src_rdy = 1; s4_src_data = 8'(i); s4_dst_ack = 1; s4_flush = 0;
            #1;
            if (i == 0) chk4("stream", i, 1'b1, 1'b0, 0, 8'h00);
            else        chk4("stream", i, 1'b1, 1'b1, 1, 8'(i - 1));
        end
        @(posedge clk); #1;
        s4_src_rdy = 0; s4_dst_ack = 1;
        #1 chk4("stream_tail", 0, 1'b0, 1'b1, 1, 8'd19);
        @(posedge clk); #1;
        idle4();
        #1 chk4("stream_end", 0, 1'b0, 1'b0, 0, 8'h00);

        // ---------------- randomized traffic vs queue model (NDATA=3) ----
        acc = 0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            // Source keeps an unaccepted offer stable.
            if (!(s3_src_rdy && !acc)) begin
                s3_src_rdy  = ($urandom_range(0, 3) != 0);
                s3_src_data = 8'($urandom);
            end
            s3_dst_ack = ($urandom_range(0, 99) < (((c / 32) % 2 == 1) ? 75 : 30));
            s3_flush   = ($urandom_range(0, 19) == 0);
            #1;
            e_sack = s3_src_rdy && (q.size() < 3) && !s3_flush;
            chk("rnd_src_ack", c, int'(s3_src_ack), int'(e_sack));
            chk("rnd_dst_rdy", c, int'(s3_dst_rdy), int'(q.size() != 0));
            chk("rnd_count",   c, int'(s3_count), q.size());
            chk("rnd_afull",   c, int'(s3_afull), int'(q.size() >= 2));
            chk("rnd_aempty",  c, int'(s3_aempty), int'(q.size() <= 1));
            if (q.size() != 0) chk("rnd_data", c, int'(s3_dst_data), int'(q[0]));
            if (s3_flush) begin
                q.delete();
            end else begin
                if (s3_dst_ack && q.size() != 0) void'(q.pop_front());
                if (e_sack) q.push_back(s3_src_data);
            end
            acc = e_sack;
        end
        @(posedge clk); #1;
        s3_src_rdy = 0; s3_dst_ack = 0; s3_flush = 0;

        // ---------------- async reset mid-stream (NDATA=4) ----------------
        @(posedge clk); #1;
        s4_src_rdy = 1; s4_src_data = 8'hC1;
        @(posedge clk); #1;
        s4_src_data = 8'hC2;
        @(posedge clk); #1;
        idle4();
        #1 chk4("pre_reset", 0, 1'b0, 1'b1, 2, 8'hC1);
        #1 rstn = 0;
        #1 chk4("async_reset", 0, 1'b0, 1'b0, 0, 8'h00);
        repeat (2) @(posedge clk);
        #1 rstn = 1;
        @(posedge clk); #1;
        s4_src_rdy = 1; s4_src_data = 8'h3C;
        #1 chk4("post_reset_push", 0, 1'b1, 1'b0, 0, 8'h00);
        @(posedge clk); #1;
        idle4();
        #1 chk4("post_reset_head", 0, 1'b0, 1'b1, 1, 8'h3C);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
